inj_flit_buffer: RTL
====================

Name: inj_flit_buffer

Overview:
- Synthesizable packet injector buffer between a host-side word loader and the many-core source ports (MA and APP injection ports of PhiversMC).
- Stores host-pushed 32-bit flits in a FIFO and emits them with the rx/credit/data handshake.
- Tracks packet framing (header, size, payload) so that end-of-applications (eoa) is raised only on a packet boundary.
- Replaces the simulation-only task parser for FPGA/ASIC bring-up.

Parameters:
- DEPTH, 16, FIFO depth in flits; power of two, >= 4.
- FLIT_SIZE, 32, flit width in bits.
- MAX_PAYLOAD, 1024, largest legal size-flit value; larger values set err_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- host_valid_i  in  1  host offers a flit.
- host_ready_o  out  1  buffer accepts a flit (FIFO not full).
- host_data_i  in  FLIT_SIZE  flit from host.
- host_eoa_i  in  1  single-cycle strobe: host will send no more packets.
- tx_o  out  1  flit valid toward many-core (connects to *_src_rx_i).
- credit_i  in  1  many-core can accept (from *_src_credit_o).
- data_o  out  FLIT_SIZE  flit toward many-core.
- eoa_o  out  1  end of applications (to app_src_eoa_i).
- pkt_count_o  out  16  completed packets sent; wraps at 65535 -> 0.
- err_o  out  1  sticky: a size flit exceeded MAX_PAYLOAD.

Behaviour:
- Reset (async, active-high): FIFO empty; FSM = HEADER; counters 0; host_ready_o = 1 after reset release (0 while rst_i high); tx_o = 0, data_o = 0, eoa_o = 0, pkt_count_o = 0, err_o = 0. Reset mid-packet discards all buffered flits and any latched eoa request.
- Push: occurs when host_valid_i && host_ready_o. host_ready_o = !full, derived from registered state.
- Pop: occurs when tx_o && credit_i. tx_o = !empty. data_o = FIFO head (first-word fall-through).
- Latency: a flit pushed at edge t is on data_o with tx_o = 1 from cycle t+1.
- Full: push and pop in the same cycle is impossible because ready is low. One pop frees a slot: host_ready_o rises the next cycle.
- Empty: push and pop in the same cycle is impossible because tx_o is low.
- Otherwise, simultaneous push and pop keeps the occupancy unchanged.
- data_o holds its value while tx_o = 1 && credit_i = 0. It must not change until the flit is popped.
- Pointers are log2(DEPTH) bits wrapping naturally. A separate occupancy counter of log2(DEPTH)+1 bits yields full/empty.
- Framing FSM advances on pops only:
  - HEADER: pop -> SIZE.
  - SIZE: pop latches data_o[15:0] into rem.
    - If the value is 0: pkt_count_o++ and -> HEADER.
    - Else -> PAYLOAD.
    - If the value > MAX_PAYLOAD: err_o <= 1 (sticky); the flit is still forwarded.
  - PAYLOAD: each pop rem--. The pop with rem == 1 does pkt_count_o++ and -> HEADER.
- eoa:
  - host_eoa_i sets the eoa_req flag.
  - eoa_o <= 1 when eoa_req && FSM == HEADER && FIFO empty && no push this cycle.
  - eoa_o is sticky until reset.
  - host_ready_o is forced to 0 once eoa_o = 1; later host_valid_i is ignored.
- host_eoa_i arriving mid-packet: eoa_o is delayed until the final payload flit is popped and the FIFO is drained.
- host_eoa_i in the same cycle as a push: the push is accepted, and eoa waits for that flit's packet to finish.

Decomposition:
- PhiversPkg gets:
  - INJ_DEPTH and INJ_MAX_PAYLOAD defaults.
  - enum inj_frame_t {FRAME_HEADER, FRAME_SIZE, FRAME_PAYLOAD}.
  - A localparam for the size-field width (16).
- One sub-module, inj_flit_fifo: parameterized FWFT synchronous FIFO (DEPTH, FLIT_SIZE) with push/pop/full/empty/head.
- inj_flit_buffer holds the framing FSM, counters and eoa logic.

Test Plan:
- Single packet:
  - Stimulus: push 0x00000102, 0x00000002, 0xAAAA0001, 0xAAAA0002 with credit_i = 1.
  - Response: 4 flits on data_o in order, first one cycle after its push; pkt_count_o = 1; FSM back to HEADER.
- Backpressure/full (DEPTH = 16):
  - Stimulus: credit_i = 0, push 20 flits.
  - Response: host_ready_o = 0 after 16 accepted. data_o stable at the first flit. Raising credit_i for 1 cycle pops exactly 1 flit, and host_ready_o = 1 on the next cycle.
- Zero-size packet:
  - Stimulus: header 0x00000203, size 0.
  - Response: pkt_count_o increments on the size-flit pop; the next flit is treated as a header.
- eoa mid-packet:
  - Stimulus: host_eoa_i pulsed after size = 3 and 1 payload flit are pushed; the remaining 2 payload flits are pushed later.
  - Response: eoa_o stays 0 until the last payload flit is popped and the FIFO is empty, then eoa_o = 1 and host_ready_o = 0.
- Oversize:
  - Stimulus: size flit 0x00000801 with MAX_PAYLOAD = 1024.
  - Response: err_o = 1 from the cycle after the pop; all 2049 payload flits are forwarded; pkt_count_o = 1.
- Reset mid-operation:
  - Stimulus: assert rst_i asynchronously with 5 flits buffered in PAYLOAD.
  - Response: tx_o, eoa_o, pkt_count_o and err_o are 0 immediately. After release the FIFO is empty and the first new push is treated as a header.

Source files
------------

// File: rtl/inj_flit_buffer_pkg.sv
// Shared types and defaults for the packet injector buffer.
package inj_flit_buffer_pkg;

  localparam int INJ_DEPTH       = 16;
  localparam int INJ_FLIT_SIZE   = 32;
  localparam int INJ_MAX_PAYLOAD = 1024;
  localparam int SIZE_FIELD_W    = 16;

  typedef enum logic [1:0] {
    FRAME_HEADER  = 2'd0,
    FRAME_SIZE    = 2'd1,
    FRAME_PAYLOAD = 2'd2
  } inj_frame_t;

  // True when a size field announces more payload flits than the system allows.
  function automatic logic size_oversize(input logic [SIZE_FIELD_W-1:0] size_i,
                                         input logic [31:0]             max_i);
    logic [31:0] size_ext;
    size_ext = {{(32-SIZE_FIELD_W){1'b0}}, size_i};
    return (size_ext > max_i);
  endfunction

endpackage

// File: rtl/inj_flit_buffer_fifo.sv
// First-word fall-through synchronous FIFO; head is valid whenever empty_o is low.
module inj_flit_fifo #(
  parameter int DEPTH     = 16,
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [FLIT_SIZE-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  logic [FLIT_SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/inj_flit_buffer.sv
// Packet injector: buffers host flits, forwards them with rx/credit handshake,
// tracks header/size/payload framing and raises eoa only on a packet boundary.
module inj_flit_buffer
  import inj_flit_buffer_pkg::*;
#(
  parameter int DEPTH       = INJ_DEPTH,
  parameter int FLIT_SIZE   = INJ_FLIT_SIZE,
  parameter int MAX_PAYLOAD = INJ_MAX_PAYLOAD
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 host_valid_i,
  output logic                 host_ready_o,
  input  logic [FLIT_SIZE-1:0] host_data_i,
  input  logic                 host_eoa_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 eoa_o,
  output logic [15:0]          pkt_count_o,
  output logic                 err_o
);

  localparam logic [SIZE_FIELD_W-1:0] REM_ONE = SIZE_FIELD_W'(1);

  logic                    full_s, empty_s, push_s, pop_s;
  logic [FLIT_SIZE-1:0]    head_s;
  logic [SIZE_FIELD_W-1:0] size_s;

  inj_frame_t              state_q, state_d;
  logic [SIZE_FIELD_W-1:0] rem_q, rem_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    eoa_req_q, eoa_req_d;
  logic                    eoa_q, eoa_d;

  inj_flit_fifo #(
    .DEPTH     (DEPTH),
    .FLIT_SIZE (FLIT_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .data_i  (host_data_i),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .head_o  (head_s)
  );

  assign host_ready_o = !rst_i && !full_s && !eoa_q;
  assign push_s       = host_valid_i && host_ready_o;
  assign tx_o         = !empty_s;
  assign pop_s        = tx_o && credit_i;
  assign data_o       = empty_s ? '0 : head_s;
  assign size_s       = head_s[SIZE_FIELD_W-1:0];
  assign pkt_count_o  = cnt_q;
  assign err_o        = err_q;
  assign eoa_o        = eoa_q;

  // Framing FSM, packet counter and eoa qualification; all advance on pops only.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    eoa_req_d = eoa_req_q | host_eoa_i;
    eoa_d     = eoa_q | (eoa_req_q && (state_q == FRAME_HEADER) && empty_s && !push_s);
    if (pop_s) begin
      case (state_q)
        FRAME_HEADER: begin
          state_d = FRAME_SIZE;
        end
        FRAME_SIZE: begin
          rem_d = size_s;
          if (size_oversize(size_s, 32'(MAX_PAYLOAD))) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (size_s == '0) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = FRAME_HEADER;
          end else begin
            state_d = FRAME_PAYLOAD;
          end
        end
        FRAME_PAYLOAD: begin
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = FRAME_HEADER;
          end else begin
            state_d = FRAME_PAYLOAD;
          end
        end
        default: begin
          state_d = FRAME_HEADER;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Framing and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FRAME_HEADER;
      rem_q     <= '0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
      eoa_req_q <= 1'b0;
      eoa_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      eoa_req_q <= eoa_req_d;
      eoa_q     <= eoa_d;
    end
  end

endmodule
